// File: rtl/trace_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// trace_mem_ctrl_if
// Bundles the three buses of the trace memory controller:
//   in_*    valid/ready trace word stream from the trace source
//   host_*  pipelined host read port toward the HPS bridge
//   mem_*   single-port trace RAM port (2-cycle read latency)
// Modports:
//   slave   controller view (accepts trace words and host reads, drives RAM)
//   master  environment view (trace source, host and RAM together)
// -----------------------------------------------------------------------------
interface trace_mem_ctrl_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_data;

   logic                  host_read;
   logic [ADDR_W-1:0]     host_address;
   logic                  host_waitrequest;
   logic [DATA_W-1:0]     host_readdata;
   logic                  host_readdatavalid;

   logic [ADDR_W-1:0]     mem_address;
   logic                  mem_chipselect;
   logic                  mem_write;
   logic [DATA_W/8-1:0]   mem_byteenable;
   logic [DATA_W-1:0]     mem_writedata;
   logic                  mem_clken;
   logic                  mem_reset_req;
   logic [DATA_W-1:0]     mem_readdata;

   modport slave (
      input  in_valid, in_data, host_read, host_address, mem_readdata,
      output in_ready, host_waitrequest, host_readdata, host_readdatavalid,
      output mem_address, mem_chipselect, mem_write, mem_byteenable,
      output mem_writedata, mem_clken, mem_reset_req
   );

   modport master (
      output in_valid, in_data, host_read, host_address, mem_readdata,
      input  in_ready, host_waitrequest, host_readdata, host_readdatavalid,
      input  mem_address, mem_chipselect, mem_write, mem_byteenable,
      input  mem_writedata, mem_clken, mem_reset_req
   );
endinterface

// File: rtl/trace_mem_ctrl.sv
// -----------------------------------------------------------------------------
// trace_mem_ctrl
// Captures a valid/ready trace word stream into a single-port trace RAM used
// as a circular buffer, and shares that RAM port with a pipelined host read
// interface. Capture writes have priority; a starvation counter forces a host
// grant (stalling the trace source for one cycle) after STARVE_MAX lost cycles.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ctrl_arm, ctrl_stop   control pulses (arm wins when both are high)
//   bus (slave)           trace stream, host read port and RAM port
//   st_state              00 IDLE, 01 CAPTURE, 10 STOPPED
//   st_wr_ptr             next physical write address
//   st_wrapped            buffer has wrapped at least once
//   st_count              stored words, saturating at DEPTH
//   st_drop_cnt           (TRACE_MEM_CTRL_STOP_ON_FULL_EN only) words dropped
//                         while STOPPED, saturating at 16'hFFFF
//
// Optional feature macro: TRACE_MEM_CTRL_STOP_ON_FULL_EN
//   undefined: circular overwrite, capture runs until ctrl_stop
//   defined:   capture stops itself once DEPTH words are stored
// -----------------------------------------------------------------------------
module trace_mem_ctrl #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ctrl_arm,
   input  logic              ctrl_stop,
   trace_mem_ctrl_if.slave   bus,
   output logic [1:0]        st_state,
   output logic [ADDR_W-1:0] st_wr_ptr,
   output logic              st_wrapped,
`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
   output logic [ADDR_W:0]   st_count,
   output logic [15:0]       st_drop_cnt
`else
   output logic [ADDR_W:0]   st_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CAPTURE = 2'b01,
      S_STOPPED = 2'b10
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [7:0]      STARVE_LIM = 8'(STARVE_MAX);

   state_t              state;
   logic [ADDR_W-1:0]   wr_ptr;
   logic                wrapped;
   logic [ADDR_W:0]     count;
   logic [7:0]          starve_cnt;
   logic                vld_p1;
   logic                vld_p2;
`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
   logic [15:0]         drop_cnt;
`endif

   logic                capture;
   logic                starve_force;
   logic                ready;
   logic                wr_en;
   logic                rd_grant;
   logic [ADDR_W-1:0]   rd_phys;
   logic [DATA_W-1:0]   wr_data;

   function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
      return (c == FULL_CNT) ? c : c + 1'b1;
   endfunction

`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
   function automatic logic [15:0] sat_drop(input logic [15:0] d);
      return (d == 16'hFFFF) ? d : d + 16'd1;
   endfunction
`endif

   // Arbitration: the capture write owns the port unless the host has waited
   // STARVE_MAX cycles, in which case the source is stalled for this cycle.
   // Outside CAPTURE the source is always ready and its words are dropped.
   assign capture      = (state == S_CAPTURE);
   assign starve_force = bus.host_read && (starve_cnt >= STARVE_LIM);
   assign ready        = !(capture && starve_force);
   assign wr_en        = capture && bus.in_valid && ready;
   // reset_n gating keeps the RAM deselected while reset is held
   assign rd_grant     = bus.host_read && reset_n && !wr_en;

   // Host index 0 is the oldest word: after a wrap that is the slot about to
   // be overwritten next, i.e. wr_ptr.
   assign rd_phys      = wrapped ? (wr_ptr + bus.host_address) : bus.host_address;
   assign wr_data      = bus.in_data;

   assign bus.in_ready           = ready;
   assign bus.host_waitrequest   = bus.host_read && !rd_grant;
   assign bus.host_readdata      = bus.mem_readdata;
   assign bus.host_readdatavalid = vld_p2;

   assign bus.mem_address    = wr_en ? wr_ptr : rd_phys;
   assign bus.mem_chipselect = wr_en || rd_grant;
   assign bus.mem_write      = wr_en;
   assign bus.mem_byteenable = '1;
   assign bus.mem_writedata  = wr_data;
   assign bus.mem_clken      = 1'b1;
   assign bus.mem_reset_req  = 1'b0;

   assign st_state   = state;
   assign st_wr_ptr  = wr_ptr;
   assign st_wrapped = wrapped;
   assign st_count   = count;
`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
   assign st_drop_cnt = drop_cnt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         wrapped    <= 1'b0;
         count      <= '0;
         starve_cnt <= '0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
         drop_cnt   <= '0;
`endif
      end else begin
         // p0 -> p1: grant issued, RAM registers the address
         vld_p1 <= rd_grant;
         // p1 -> p2: RAM output stage, data valid on host_readdata
         vld_p2 <= vld_p1;

         if (rd_grant)
            starve_cnt <= '0;
         else if (bus.host_read)
            starve_cnt <= starve_cnt + 8'd1;

         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == '1)
               wrapped <= 1'b1;
            count <= sat_count(count);
         end

`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
         if (state == S_STOPPED && bus.in_valid)
            drop_cnt <= sat_drop(drop_cnt);
`endif

         // Arm overrides any pointer update made by a write in the same cycle
         if (ctrl_arm) begin
            state   <= S_CAPTURE;
            wr_ptr  <= '0;
            wrapped <= 1'b0;
            count   <= '0;
`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
            drop_cnt <= '0;
`endif
         end else if (ctrl_stop && state == S_CAPTURE) begin
            state <= S_STOPPED;
         end
`ifdef TRACE_MEM_CTRL_STOP_ON_FULL_EN
         else if (wr_en && count == FULL_CNT - 1'b1) begin
            state <= S_STOPPED;
         end
`endif
      end
   end

endmodule
